// File: rtl/alarm_controller_if.sv
// Control/status bundle between the alarm FSM and its surroundings.
// The master side drives tick/arm/disarm/sensor; the slave side reports status.
interface alarm_controller_if #(
   parameter int CNT_W = 4
);
   logic             tick;
   logic             arm;
   logic             disarm;
   logic             sensor;
   logic             armed;
   logic             siren;
   logic             beeper;
   logic [2:0]       state;
   logic [CNT_W-1:0] countdown;

   modport master (
      output tick, arm, disarm, sensor,
      input  armed, siren, beeper, state, countdown
   );

   modport slave (
      input  tick, arm, disarm, sensor,
      output armed, siren, beeper, state, countdown
   );
endinterface

// File: rtl/alarm_controller.sv
// Arming/alarm sequencer timed by prescaler tick edges.
// Optional macro ALARM_SENSOR_SYNC_EN adds a two-flop synchroniser on sensor.
module alarm_controller #(
   parameter int EXIT_TICKS  = 8,
   parameter int ENTRY_TICKS = 6,
   parameter int SIREN_TICKS = 15,
   parameter int CNT_W       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   alarm_controller_if.slave   bus
);

   typedef enum logic [2:0] {
      DISARMED    = 3'd0,
      EXIT_DELAY  = 3'd1,
      ARMED       = 3'd2,
      ENTRY_DELAY = 3'd3,
      ALARM       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_TICKS);
   localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS);
   localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             beep_q, beep_nxt;
   logic             armed_q, armed_nxt;
   logic             siren_q, siren_nxt;
   logic             tick_q;
   logic             tick_edge;
   logic             sensor_fsm;

   // A stretched strobe must count only once, so only the rising edge is used.
   assign tick_edge = bus.tick & ~tick_q;

`ifdef ALARM_SENSOR_SYNC_EN
   logic sensor_meta, sensor_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sensor_meta <= 1'b0;
         sensor_sync <= 1'b0;
      end else begin
         sensor_meta <= bus.sensor;
         sensor_sync <= sensor_meta;
      end
   end

   assign sensor_fsm = sensor_sync;
`else
   assign sensor_fsm = bus.sensor;
`endif

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      beep_nxt  = 1'b0;

      case (state_q)
         DISARMED: begin
            cnt_nxt = CNT_ZERO;
            if (bus.arm) begin
               state_nxt = EXIT_DELAY;
               cnt_nxt   = EXIT_LOAD;
            end
         end
         EXIT_DELAY: begin
            beep_nxt = beep_q;
            if (tick_edge) begin
               if (cnt_q == CNT_ONE) begin
                  state_nxt = ARMED;
                  cnt_nxt   = CNT_ZERO;
                  beep_nxt  = 1'b0;
               end else begin
                  cnt_nxt  = cnt_q - CNT_ONE;
                  beep_nxt = ~beep_q;
               end
            end
         end
         ARMED: begin
            cnt_nxt = CNT_ZERO;
            if (sensor_fsm) begin
               state_nxt = ENTRY_DELAY;
               cnt_nxt   = ENTRY_LOAD;
            end
         end
         ENTRY_DELAY: begin
            beep_nxt = beep_q;
            if (tick_edge) begin
               if (cnt_q == CNT_ONE) begin
                  state_nxt = ALARM;
                  cnt_nxt   = SIREN_LOAD;
                  beep_nxt  = 1'b0;
               end else begin
                  cnt_nxt  = cnt_q - CNT_ONE;
                  beep_nxt = ~beep_q;
               end
            end
         end
         ALARM: begin
            if (tick_edge) begin
               if (cnt_q == CNT_ONE) begin
                  state_nxt = ARMED;
                  cnt_nxt   = CNT_ZERO;
               end else begin
                  cnt_nxt = cnt_q - CNT_ONE;
               end
            end
         end
         default: begin
            state_nxt = DISARMED;
            cnt_nxt   = CNT_ZERO;
         end
      endcase

      // Disarm wins over every expiry, trip or arm request in the same cycle.
      if (bus.disarm) begin
         state_nxt = DISARMED;
         cnt_nxt   = CNT_ZERO;
         beep_nxt  = 1'b0;
      end

      armed_nxt = (state_nxt == ARMED) || (state_nxt == ENTRY_DELAY) ||
                  (state_nxt == ALARM);
      siren_nxt = (state_nxt == ALARM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DISARMED;
         cnt_q   <= CNT_ZERO;
         beep_q  <= 1'b0;
         armed_q <= 1'b0;
         siren_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         beep_q  <= beep_nxt;
         armed_q <= armed_nxt;
         siren_q <= siren_nxt;
         tick_q  <= bus.tick;
      end
   end

   assign bus.state     = state_q;
   assign bus.countdown = cnt_q;
   assign bus.beeper    = beep_q;
   assign bus.armed     = armed_q;
   assign bus.siren     = siren_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Randomised and directed bench for alarm_controller, checked against a
// period/elapsed-tick reference model of the arming sequence.
module tb_alarm_controller;

   localparam int EXIT_TICKS  = 8;
   localparam int ENTRY_TICKS = 6;
   localparam int SIREN_TICKS = 15;
   localparam int CNT_W       = 4;
`ifdef ALARM_SENSOR_SYNC_EN
   localparam int SENS_LAT = 3;
`else
   localparam int SENS_LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   alarm_controller_if #(.CNT_W(CNT_W)) bus();

   alarm_controller #(
      .EXIT_TICKS (EXIT_TICKS),
      .ENTRY_TICKS(ENTRY_TICKS),
      .SIREN_TICKS(SIREN_TICKS),
      .CNT_W      (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int tp    = 0;

   // Model: mode number, length of the current timed period, tick edges seen.
   int m_mode, m_len, m_elapsed;
   bit m_prev_tick, m_hist0, m_hist1;

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit tk, input bit a, input bit d, input bit s);
      bus.tick   = tk;
      bus.arm    = a;
      bus.disarm = d;
      bus.sensor = s;
   endtask

   task automatic modelReset();
      m_mode      = 0;
      m_len       = 0;
      m_elapsed   = 0;
      m_prev_tick = 1'b0;
      m_hist0     = 1'b0;
      m_hist1     = 1'b0;
   endtask

   task automatic modelEnter(input int mode, input int len);
      m_mode    = mode;
      m_len     = len;
      m_elapsed = 0;
   endtask

   task automatic modelStep(input bit tk, input bit a, input bit d, input bit s);
      bit te, s_eff;
      te          = tk && !m_prev_tick;
      m_prev_tick = tk;
`ifdef ALARM_SENSOR_SYNC_EN
      s_eff   = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = s;
`else
      s_eff = s;
`endif
      if (d) modelEnter(0, 0);
      else if (m_mode == 0) begin
         if (a) modelEnter(1, EXIT_TICKS);
      end else if (m_mode == 2) begin
         if (s_eff) modelEnter(3, ENTRY_TICKS);
      end else if (te) begin
         m_elapsed++;
         if (m_elapsed == m_len) begin
            if (m_mode == 3) modelEnter(4, SIREN_TICKS);
            else             modelEnter(2, 0);
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("state", 32'(bus.state), m_mode);
      checkOutput("countdown", 32'(bus.countdown), m_len - m_elapsed);
      checkOutput("armed", 32'(bus.armed), (m_mode >= 2 && m_mode <= 4) ? 1 : 0);
      checkOutput("siren", 32'(bus.siren), (m_mode == 4) ? 1 : 0);
      checkOutput("beeper", 32'(bus.beeper),
                  ((m_mode == 1 || m_mode == 3) && (m_elapsed % 2 == 1)) ? 1 : 0);
   endtask

   task automatic cycle(input bit tk, input bit a, input bit d, input bit s);
      applyStimulus(tk, a, d, s);
      @(posedge clk);
      modelStep(tk, a, d, s);
      @(negedge clk);
      checkAll();
   endtask

   task automatic tickCycle(input bit a, input bit d, input bit s);
      cycle((tp % 16) == 15, a, d, s);
      tp++;
   endtask

   task automatic runUntil(input int mode, input int budget, input bit s, input string tag);
      int n = 0;
      while (m_mode != mode && n < budget) begin
         tickCycle(1'b0, 1'b0, s);
         n++;
      end
      checkOutput(tag, 32'(bus.state), mode);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkAll();
      rst_n = 1'b1;
      tp    = 0;
   endtask

   initial begin
      int toggles, lat;
      bit prev_beep;

      $display("[TB] alarm_controller bench start");
      doReset();

      // Arm and run out the exit delay with a 1-in-16 tick.
      tickCycle(1'b1, 1'b0, 1'b0);
      checkOutput("arm_state", 32'(bus.state), 1);
      checkOutput("arm_count", 32'(bus.countdown), EXIT_TICKS);
      toggles   = 0;
      prev_beep = bus.beeper;
      lat       = 0;
      while (m_mode != 2 && lat < 16 * EXIT_TICKS + 32) begin
         tickCycle(1'b0, 1'b0, 1'b0);
         if (bus.beeper != prev_beep) toggles++;
         prev_beep = bus.beeper;
         lat++;
      end
      checkOutput("exit_toggles", toggles, EXIT_TICKS);
      checkOutput("armed_flag", 32'(bus.armed), 1);

      // Sensor trip, entry delay, siren period and automatic re-arm.
      lat = 0;
      do begin
         tickCycle(1'b0, 1'b0, 1'b1);
         lat++;
      end while (bus.state != 3'd3 && lat < 8);
      checkOutput("sensor_latency", lat, SENS_LAT);
      checkOutput("entry_count", 32'(bus.countdown), ENTRY_TICKS);
      runUntil(4, 16 * ENTRY_TICKS + 32, 1'b0, "alarm_reached");
      checkOutput("siren_on", 32'(bus.siren), 1);
      checkOutput("siren_count", 32'(bus.countdown), SIREN_TICKS);
      runUntil(2, 16 * SIREN_TICKS + 32, 1'b0, "rearmed");

      // Disarm coinciding with the expiring entry-delay tick edge.
      runUntil(3, 8, 1'b1, "entry_again");
      lat = 0;
      while ((m_len - m_elapsed) != 1 && lat < 16 * ENTRY_TICKS + 32) begin
         tickCycle(1'b0, 1'b0, 1'b0);
         lat++;
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("disarm_expiry_state", 32'(bus.state), 0);
      checkOutput("disarm_expiry_siren", 32'(bus.siren), 0);
      checkOutput("disarm_expiry_count", 32'(bus.countdown), 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Arm/disarm conflict, then a tick held high for five cycles.
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("conflict_state", 32'(bus.state), 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("stretched_count", 32'(bus.countdown), EXIT_TICKS - 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Random traffic; sensor changes slowly so trips persist for a while.
      begin
         bit s_rand = 1'b0;
         repeat (4000) begin
            if ($urandom_range(19, 0) == 0) s_rand = ~s_rand;
            cycle($urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0,
                  $urandom_range(149, 0) == 0, s_rand);
         end
      end

      // Asynchronous reset in the middle of an alarm.
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      tp = 0;
      tickCycle(1'b1, 1'b0, 1'b0);
      runUntil(2, 16 * EXIT_TICKS + 32, 1'b0, "pre_reset_armed");
      runUntil(4, 16 * ENTRY_TICKS + 40, 1'b1, "pre_reset_alarm");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_state", 32'(bus.state), 0);
      checkOutput("async_siren", 32'(bus.siren), 0);
      checkOutput("async_armed", 32'(bus.armed), 0);
      checkOutput("async_beeper", 32'(bus.beeper), 0);
      checkOutput("async_count", 32'(bus.countdown), 0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      // A tick already high right after reset counts as an edge.
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_count", 32'(bus.countdown), EXIT_TICKS - 1);
      repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Arming/alarm state machine that sits directly downstream of the 16-cycle prescaler: it consumes the prescaler's one-cycle terminal-count strobe as its time base (`tick`), sequences exit delay, armed watch, entry delay and siren periods, and drives the siren and beeper outputs of the alarm system. All timing is counted in tick edges, never in raw clocks, so the block's real-time behaviour scales with the prescaler period.

## Interface
- `EXIT_TICKS`, 8: tick edges spent in EXIT_DELAY after arming; legal range 1..2^CNT_W-1.
- `ENTRY_TICKS`, 6: tick edges spent in ENTRY_DELAY after a sensor trip; legal range 1..2^CNT_W-1.
- `SIREN_TICKS`, 15: tick edges the siren sounds; legal range 1..2^CNT_W-1.
- `CNT_W`, 4: countdown width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: prescaler terminal-count strobe, nominally high one cycle in sixteen.
- `arm` in 1: arm request, sampled every cycle.
- `disarm` in 1: disarm request, sampled every cycle.
- `sensor` in 1: zone sensor level; 1 = tripped.
- `armed` out 1: high in ARMED, ENTRY_DELAY and ALARM.
- `siren` out 1: high in ALARM only.
- `beeper` out 1: warning tone; toggles on tick edges during the two delay states.
- `state` out 3: encoded state (DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4).
- `countdown` out CNT_W: tick edges remaining in the current timed state; 0 in untimed states.

## Operation
- **Tick edge detection.**
  - `tick_q` registers `tick`; `tick_edge = tick & ~tick_q`.
  - A strobe held high for multiple cycles counts once.
  - `tick_q` resets to 0, so a `tick` already high on the first cycle after reset counts as one edge.
- **DISARMED.**
  - On `arm` = 1 and `disarm` = 0: go to EXIT_DELAY, load `countdown` = EXIT_TICKS.
- **EXIT_DELAY.**
  - Each `tick_edge` decrements `countdown`.
  - On a `tick_edge` with `countdown` == 1: go to ARMED with `countdown` = 0.
  - `sensor` is ignored.
- **ARMED.**
  - `sensor` = 1: go to ENTRY_DELAY, load ENTRY_TICKS.
- **ENTRY_DELAY.**
  - Each `tick_edge` decrements `countdown`.
  - On a `tick_edge` with `countdown` == 1: go to ALARM, load SIREN_TICKS.
  - `sensor` is ignored.
- **ALARM.**
  - Each `tick_edge` decrements `countdown`.
  - On a `tick_edge` with `countdown` == 1: return to ARMED with `countdown` = 0 (automatic re-arm).
  - `sensor` is ignored; a still-tripped sensor re-enters ENTRY_DELAY on the following cycle.
- **Priority.**
  - `disarm` = 1 in any state forces DISARMED, `countdown` = 0, `beeper` = 0. It overrides any simultaneous tick expiry or sensor trip.
  - `arm` is ignored outside DISARMED.
  - `arm` and `disarm` asserted together in DISARMED: remain DISARMED.
- **Beeper.**
  - Cleared on entry to EXIT_DELAY and ENTRY_DELAY.
  - Toggles on every `tick_edge` while in either delay state.
  - Forced to 0 in every other state.
- **Encodings.** States 5..7 are unreachable; if ever entered, go to DISARMED on the next cycle.

## Timing
- **Reset values.** `state` = DISARMED, `countdown` = 0, `armed` = 0, `siren` = 0, `beeper` = 0, `tick_q` = 0, synchroniser flops = 0. Reset takes effect immediately, including mid-delay or mid-alarm.
- **Registered outputs.** All outputs are registered and consistent with `state` in the same cycle.
- **Latency.**
  - `arm`, `disarm`, `tick` rise: response visible after 1 clock edge.
  - `sensor`: response visible after 1 edge (no synchroniser) or 3 edges (with synchroniser).
- **Period lengths.** Each timed state lasts exactly N tick edges after entry, where N is the loaded value. The first counted edge is the first `tick_edge` after the cycle of entry; a tick edge in the cycle that loads the counter is not counted.
- **Decrement rule.** `countdown` decrements on the same edge that registers `tick_edge`. At the expiring edge it never shows 0 before the transition; it goes straight to the next loaded value.

## Configuration
- **`ALARM_SENSOR_SYNC_EN` defined:** `sensor` passes through a two-flop synchroniser (reset 0) before the FSM. Trip-to-ENTRY_DELAY latency is 3 clock edges.
- **Not defined:** `sensor` feeds the FSM directly. Latency is 1 edge, and the caller guarantees `sensor` is synchronous to `clk`.

## Test plan
- **Reset and arm.** Reset, then pulse `arm` for 1 cycle; drive `tick` high 1 of every 16 cycles. Required: `state` = 1 and `countdown` = 8 one edge later. `countdown` steps 8→1 on successive ticks. `state` = 2, `armed` = 1 on the 8th tick edge. `beeper` toggles 8 times.
- **Entry delay and siren.** In ARMED, raise `sensor`. Required: ENTRY_DELAY with `countdown` = 6 after 1 edge (3 edges with `ALARM_SENSOR_SYNC_EN`). `siren` = 1 and `countdown` = 15 on the 6th tick edge. Back to ARMED after 15 more tick edges.
- **Disarm against expiry.** Assert `disarm` in the same cycle as the expiring tick edge of ENTRY_DELAY. Required: DISARMED, `siren` = 0, `countdown` = 0, no ALARM cycle.
- **Arm/disarm conflict and stretched tick.** In DISARMED, assert `arm` and `disarm` together → remains DISARMED. Hold `tick` high for 5 cycles during EXIT_DELAY → `countdown` decrements once.
- **Asynchronous reset mid-alarm.** Drop `rst_n` mid-cycle during ALARM. Required: `siren`, `armed`, `beeper` = 0 and `state` = 0 before the next clock edge.
